memory_content_tester: RTL and testbench

- Small word-addressed scratch RAM used as a self-checking target in CPU test benches.
- Sits on the CPU data bus next to program ROM; its read data is OR-combined with other slaves, so it drives zero when not selected.
- Continuously compares its stored contents against a reference image fixed at elaboration and raises content_ok when every word matches.

---
 rtl/memory_content_tester.sv | 71 +++++++
 tb/tb_memory_content_tester.sv | 136 +++++++++++++
 2 files changed

// File: rtl/memory_content_tester.sv
// Word-addressed scratch RAM for CPU test benches. Reads are registered and
// drive zero when the address is outside this block's window, so the output
// can be OR-combined with other bus slaves. content_ok flags when every stored
// word equals the reference image fixed at elaboration.
module memory_content_tester #(
    parameter int unsigned base_addr  = 1024,
    parameter int unsigned addr_size  = 30,
    parameter int unsigned array_size = 4,
    parameter int unsigned word_size  = 32,
    parameter logic [array_size*word_size-1:0] array_content =
        128'h0D0C0B0A_0304EF00_01020304_ABCDEF00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [addr_size-1:0] addr,
    input  logic [word_size-1:0] data_in,
    input  logic                 write_en,
    output logic [word_size-1:0] data_out,
    output logic                 content_ok
);

    localparam int unsigned IDX_W = (array_size > 1) ? $clog2(array_size) : 1;
    localparam logic [addr_size-1:0] ADDR_LO = addr_size'(base_addr);
    localparam logic [addr_size-1:0] ADDR_HI = addr_size'(base_addr + array_size);

    logic [word_size-1:0] r_mem [array_size];
    logic                 w_sel;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_match;

    // Address decode: unsigned window [base_addr, base_addr + array_size)
    always_comb begin
        w_sel = (addr >= ADDR_LO) && (addr < ADDR_HI);
        w_idx = IDX_W'(addr - ADDR_LO);
    end

    // Storage: full-word writes to the selected index, cleared on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(array_size); i++) begin
                r_mem[i] <= '0;
            end
        end else if (write_en && w_sel) begin
            r_mem[w_idx] <= data_in;
        end
    end

    // Registered read; old word is returned on a same-cycle write (read-before-write)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else if (w_sel) begin
            data_out <= r_mem[w_idx];
        end else begin
            data_out <= '0;
        end
    end

    // Compare every stored word against its slice of the reference image
    always_comb begin
        w_match = 1'b1;
        for (int i = 0; i < int'(array_size); i++) begin
            if (r_mem[i] != array_content[i*word_size +: word_size]) begin
                w_match = 1'b0;
            end
        end
    end

    assign content_ok = w_match;

endmodule

// File: tb/tb_memory_content_tester.sv
// Directed bench for memory_content_tester: reset, write/read-back, full
// reference match, out-of-range safety, read/write collision, async reset.
module tb_memory_content_tester;

    logic        clk;
    logic        reset;
    logic [29:0] addr;
    logic [31:0] data_in;
    logic        write_en;
    logic [31:0] data_out;
    logic        content_ok;

    int errors = 0;
    int checks = 0;

    memory_content_tester dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .data_in   (data_in),
        .write_en  (write_en),
        .data_out  (data_out),
        .content_ok(content_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d);
        addr = a; data_in = d; write_en = 1'b1;
        tick();
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [29:0] a);
        addr = a; write_en = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; addr = '0; data_in = '0; write_en = 1'b0;
        #12;
        check("reset_dout", data_out, 32'h0);
        check("reset_ok", 32'(content_ok), 32'h0);
        #10;
        reset = 1'b0;

        // All words cleared after reset
        for (int i = 0; i < 4; i++) begin
            rd(30'(1024 + i));
            check($sformatf("reset_mem%0d", i), data_out, 32'h0);
        end

        // Write/read-back word 0; write cycle itself returns the old value
        wr(30'd1024, 32'hABCDEF00);
        check("wr0_old", data_out, 32'h0);
        rd(30'd1024);
        check("rd0", data_out, 32'hABCDEF00);
        check("ok_partial0", 32'(content_ok), 32'h0);

        // Fill the remaining words; match only after the last one
        wr(30'd1025, 32'h01020304);
        wr(30'd1026, 32'h0304EF00);
        check("ok_partial2", 32'(content_ok), 32'h0);
        wr(30'd1027, 32'h0D0C0B0A);
        check("ok_full", 32'(content_ok), 32'h1);
        rd(30'd1025);
        check("rd1", data_out, 32'h01020304);

        // Break and repair word 1
        wr(30'd1025, 32'h00000000);
        check("ok_broken", 32'(content_ok), 32'h0);
        wr(30'd1025, 32'h01020304);
        check("ok_repaired", 32'(content_ok), 32'h1);

        // Out-of-range writes ignored, reads return zero
        wr(30'd1023, 32'hFFFFFFFF);
        check("oor_wr_lo_dout", data_out, 32'h0);
        wr(30'd1028, 32'hFFFFFFFF);
        check("oor_wr_hi_dout", data_out, 32'h0);
        check("oor_ok", 32'(content_ok), 32'h1);
        rd(30'd1027);
        check("rd3", data_out, 32'h0D0C0B0A);
        rd(30'd1023);
        check("oor_rd_lo", data_out, 32'h0);
        rd(30'd1024);
        check("rd0_after", data_out, 32'hABCDEF00);
        rd(30'd1028);
        check("oor_rd_hi", data_out, 32'h0);
        rd(30'd0);
        check("oor_rd_zero", data_out, 32'h0);

        // Collision: same-cycle read and write to word 2
        wr(30'd1026, 32'h12345678);
        check("coll_old", data_out, 32'h0304EF00);
        check("coll_ok", 32'(content_ok), 32'h0);
        rd(30'd1026);
        check("coll_new", data_out, 32'h12345678);
        wr(30'd1026, 32'h0304EF00);
        check("coll_restore_ok", 32'(content_ok), 32'h1);

        // Asynchronous reset mid-run, not aligned to any clock edge
        rd(30'd1027);
        check("pre_rst_dout", data_out, 32'h0D0C0B0A);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_dout", data_out, 32'h0);
        check("async_rst_ok", 32'(content_ok), 32'h0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(30'(1024 + i));
            check($sformatf("post_rst_mem%0d", i), data_out, 32'h0);
        end
        check("post_rst_ok", 32'(content_ok), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
